// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the ID/EX control path: MIPS opcode and funct
// encodings, ALU operation codes, and the control bundle carried from
// ID into EX. Also holds the R-type funct -> ALU op helper.
package mips_ctrl_pkg;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2a;

   // ALU operation codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_BAD = 4'b1111;

   // Control bundle, MSB first. An all-zero bundle is a bubble.
   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memwrite;
      logic       branch;
      logic       bne;
      logic       jump;
      logic [3:0] alu_ctrl;
   } ctrl_bundle_t;

   // R-type ALU op lookup; returns {illegal, alu_ctrl}.
   function automatic logic [4:0] r_alu(input logic [5:0] funct, input logic shift_en);
      logic [4:0] res;
      res = {1'b1, ALU_BAD};
      case (funct)
         FN_ADD: res = {1'b0, ALU_ADD};
         FN_SUB: res = {1'b0, ALU_SUB};
         FN_AND: res = {1'b0, ALU_AND};
         FN_OR:  res = {1'b0, ALU_OR};
         FN_SLT: res = {1'b0, ALU_SLT};
         FN_SLL: res = shift_en ? {1'b0, ALU_SLL} : {1'b1, ALU_BAD};
         FN_SRL: res = shift_en ? {1'b0, ALU_SRL} : {1'b1, ALU_BAD};
         default: res = {1'b1, ALU_BAD};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode
// Purely combinational main + ALU control decoder.
// Ports:
//   opcode  in  6   instr[31:26]
//   funct   in  6   instr[5:0]
//   ctrl    out     decoded control bundle (alu_ctrl = ALU_BAD when illegal)
//   illegal out 1   unsupported opcode, or unsupported funct for R-type
//   uses_rt out 1   instruction reads rt as a source register
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
#(
   parameter int ENABLE_SHIFT = 1,
   parameter int ENABLE_BNE   = 1
) (
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output ctrl_bundle_t ctrl,
   output logic         illegal,
   output logic         uses_rt
);

   localparam logic SHIFT_EN = (ENABLE_SHIFT != 0);
   localparam logic BNE_EN   = (ENABLE_BNE != 0);

   logic [4:0] r_res;

   assign r_res = r_alu(funct, SHIFT_EN);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      uses_rt = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            // A bad funct keeps the R-type register-write bits; the
            // illegal flag is what downstream logic must act on.
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.alu_ctrl = r_res[3:0];
            illegal       = r_res[4];
            uses_rt       = 1'b1;
         end
         OP_LW: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.alu_ctrl = ALU_ADD;
         end
         OP_SW: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.alu_ctrl = ALU_ADD;
            uses_rt       = 1'b1;
         end
         OP_BEQ: begin
            ctrl.branch   = 1'b1;
            ctrl.alu_ctrl = ALU_SUB;
            uses_rt       = 1'b1;
         end
         OP_BNE: begin
            // rt is treated as read even when bne is disabled: a
            // conservative extra stall on an illegal op is harmless.
            uses_rt = 1'b1;
            if (BNE_EN) begin
               ctrl.branch   = 1'b1;
               ctrl.bne      = 1'b1;
               ctrl.alu_ctrl = ALU_SUB;
            end else begin
               ctrl.alu_ctrl = ALU_BAD;
               illegal       = 1'b1;
            end
         end
         OP_ADDI: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.alu_ctrl = ALU_ADD;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         default: begin
            ctrl.alu_ctrl = ALU_BAD;
            illegal       = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_control_stage.sv
// id_ex_control_stage
// Decodes the ID instruction, detects load-use hazards against the
// instruction in EX, inserts bubbles, honours EX flushes and registers the
// control bundle into the ID/EX pipeline register.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   if_id_instr/valid       instruction in ID and its valid bit
//   ex_flush                taken branch/jump in EX; squash ID
//   stall                   combinational: hold PC and IF/ID this cycle
//   id_ex_*                 registered ID/EX control bundle and reg fields
//   stall_count             saturating count of stall cycles
module id_ex_control_stage
   import mips_ctrl_pkg::*;
#(
   parameter int LOAD_USE_STALLS = 1,
   parameter int ENABLE_SHIFT    = 1,
   parameter int ENABLE_BNE      = 1,
   parameter int STALL_CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            if_id_instr,
   input  logic                   if_id_valid,
   input  logic                   ex_flush,
   output logic                   stall,
   output logic                   id_ex_valid,
   output logic                   id_ex_regdst,
   output logic                   id_ex_alusrc,
   output logic                   id_ex_memtoreg,
   output logic                   id_ex_regwrite,
   output logic                   id_ex_memwrite,
   output logic                   id_ex_branch,
   output logic                   id_ex_bne,
   output logic                   id_ex_jump,
   output logic [3:0]             id_ex_alu_ctrl,
   output logic [4:0]             id_ex_rs,
   output logic [4:0]             id_ex_rt,
   output logic [4:0]             id_ex_rd,
   output logic                   id_ex_illegal,
   output logic [STALL_CNT_W-1:0] stall_count
);

   // Extra bubbles still owed after the hazard cycle itself (0 or 1).
   localparam logic STALL_LOAD = (LOAD_USE_STALLS >= 2);

   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   ctrl_bundle_t     dec_ctrl;
   logic             dec_illegal;
   logic             dec_uses_rt;
   logic             hz;
   logic             bubble;

   logic             stall_cnt_reg;
   logic             stall_cnt_next;
   logic             valid_reg;
   ctrl_bundle_t     ctrl_reg;
   logic             illegal_reg;
   logic [4:0]       rs_reg;
   logic [4:0]       rt_reg;
   logic [4:0]       rd_reg;
   logic [STALL_CNT_W-1:0] perf_reg;

   assign opcode = if_id_instr[31:26];
   assign rs     = if_id_instr[25:21];
   assign rt     = if_id_instr[20:16];
   assign rd     = if_id_instr[15:11];
   assign funct  = if_id_instr[5:0];

   mips_ctrl_decode #(
      .ENABLE_SHIFT (ENABLE_SHIFT),
      .ENABLE_BNE   (ENABLE_BNE)
   ) u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal),
      .uses_rt (dec_uses_rt)
   );

   // A load in EX whose destination is read by the ID instruction.
   // $zero never creates a dependency.
   assign hz = valid_reg & ctrl_reg.memtoreg & (rt_reg != 5'd0) & if_id_valid &
               ((rt_reg == rs) | (dec_uses_rt & (rt_reg == rt)));

   // A flush squashes the ID instruction, so there is nothing to hold.
   assign stall  = ~ex_flush & (hz | stall_cnt_reg);
   assign bubble = ex_flush | stall | ~if_id_valid;

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (ex_flush)
         stall_cnt_next = 1'b0;
      else if (hz)
         stall_cnt_next = STALL_LOAD;
      else if (stall_cnt_reg)
         stall_cnt_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_reg <= 1'b0;
         valid_reg     <= 1'b0;
         ctrl_reg      <= '0;
         illegal_reg   <= 1'b0;
         rs_reg        <= '0;
         rt_reg        <= '0;
         rd_reg        <= '0;
         perf_reg      <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
         valid_reg     <= ~bubble;
         ctrl_reg      <= bubble ? '0 : dec_ctrl;
         illegal_reg   <= bubble ? 1'b0 : dec_illegal;
         // Register fields are captured even for bubbles; only valid and
         // the control bits decide whether EX acts on them.
         rs_reg        <= rs;
         rt_reg        <= rt;
         rd_reg        <= rd;
         if (stall && (perf_reg != {STALL_CNT_W{1'b1}}))
            perf_reg <= perf_reg + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign id_ex_valid    = valid_reg;
   assign id_ex_regdst   = ctrl_reg.regdst;
   assign id_ex_alusrc   = ctrl_reg.alusrc;
   assign id_ex_memtoreg = ctrl_reg.memtoreg;
   assign id_ex_regwrite = ctrl_reg.regwrite;
   assign id_ex_memwrite = ctrl_reg.memwrite;
   assign id_ex_branch   = ctrl_reg.branch;
   assign id_ex_bne      = ctrl_reg.bne;
   assign id_ex_jump     = ctrl_reg.jump;
   assign id_ex_alu_ctrl = ctrl_reg.alu_ctrl;
   assign id_ex_rs       = rs_reg;
   assign id_ex_rt       = rt_reg;
   assign id_ex_rd       = rd_reg;
   assign id_ex_illegal  = illegal_reg;
   assign stall_count    = perf_reg;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// tb_id_ex_control_stage
// Two instances share one stimulus stream:
//   a: LOAD_USE_STALLS=1, shifts and bne enabled, 16-bit stall counter
//   b: LOAD_USE_STALLS=2, shifts and bne disabled, 4-bit stall counter
// Each is compared every cycle against a behavioural model of its config.
module tb_id_ex_control_stage;

   typedef struct packed {
      logic       valid;
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memwrite;
      logic       branch;
      logic       bne;
      logic       jump;
      logic [3:0] alu;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       illegal;
   } ex_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        valid = 1'b0;
   logic        flush = 1'b0;

   int tests = 0;
   int failed = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   logic        a_stall, a_valid, a_regdst, a_alusrc, a_memtoreg, a_regwrite;
   logic        a_memwrite, a_branch, a_bne, a_jump, a_illegal;
   logic [3:0]  a_alu;
   logic [4:0]  a_rs, a_rt, a_rd;
   logic [15:0] a_cnt;
   logic        b_stall, b_valid, b_regdst, b_alusrc, b_memtoreg, b_regwrite;
   logic        b_memwrite, b_branch, b_bne, b_jump, b_illegal;
   logic [3:0]  b_alu;
   logic [4:0]  b_rs, b_rt, b_rd;
   logic [3:0]  b_cnt;

   id_ex_control_stage #(
      .LOAD_USE_STALLS(1), .ENABLE_SHIFT(1), .ENABLE_BNE(1), .STALL_CNT_W(16)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .if_id_instr(instr), .if_id_valid(valid),
      .ex_flush(flush), .stall(a_stall), .id_ex_valid(a_valid),
      .id_ex_regdst(a_regdst), .id_ex_alusrc(a_alusrc), .id_ex_memtoreg(a_memtoreg),
      .id_ex_regwrite(a_regwrite), .id_ex_memwrite(a_memwrite), .id_ex_branch(a_branch),
      .id_ex_bne(a_bne), .id_ex_jump(a_jump), .id_ex_alu_ctrl(a_alu),
      .id_ex_rs(a_rs), .id_ex_rt(a_rt), .id_ex_rd(a_rd),
      .id_ex_illegal(a_illegal), .stall_count(a_cnt)
   );

   id_ex_control_stage #(
      .LOAD_USE_STALLS(2), .ENABLE_SHIFT(0), .ENABLE_BNE(0), .STALL_CNT_W(4)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .if_id_instr(instr), .if_id_valid(valid),
      .ex_flush(flush), .stall(b_stall), .id_ex_valid(b_valid),
      .id_ex_regdst(b_regdst), .id_ex_alusrc(b_alusrc), .id_ex_memtoreg(b_memtoreg),
      .id_ex_regwrite(b_regwrite), .id_ex_memwrite(b_memwrite), .id_ex_branch(b_branch),
      .id_ex_bne(b_bne), .id_ex_jump(b_jump), .id_ex_alu_ctrl(b_alu),
      .id_ex_rs(b_rs), .id_ex_rt(b_rt), .id_ex_rd(b_rd),
      .id_ex_illegal(b_illegal), .stall_count(b_cnt)
   );

   ex_t a_obs, b_obs;
   assign a_obs = {a_valid, a_regdst, a_alusrc, a_memtoreg, a_regwrite, a_memwrite,
                   a_branch, a_bne, a_jump, a_alu, a_rs, a_rt, a_rd, a_illegal};
   assign b_obs = {b_valid, b_regdst, b_alusrc, b_memtoreg, b_regwrite, b_memwrite,
                   b_branch, b_bne, b_jump, b_alu, b_rs, b_rt, b_rd, b_illegal};

   // Model state, index 0 = dut_a, 1 = dut_b
   ex_t    m_ex[2];
   int     m_pend[2];
   longint m_cnt[2];
   bit     m_known[2];

   function automatic int cfg_l(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic longint cfg_max(input int k);
      return (k == 0) ? 64'd65535 : 64'd15;
   endfunction

   function automatic bit reads_rt(input logic [5:0] op);
      return (op == 6'h00) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h05);
   endfunction

   // Reference decode from the instruction-set table.
   function automatic ex_t ref_decode(input logic [31:0] ins, input int k);
      ex_t r;
      bit shift_en, bne_en, bad;
      shift_en = (k == 0);
      bne_en   = (k == 0);
      bad      = 1'b0;
      r        = '0;
      r.valid  = 1'b1;
      r.rs     = ins[25:21];
      r.rt     = ins[20:16];
      r.rd     = ins[15:11];
      case (ins[31:26])
         6'h00: begin
            r.regdst = 1'b1; r.regwrite = 1'b1;
            case (ins[5:0])
               6'h20: r.alu = 4'd2;
               6'h22: r.alu = 4'd6;
               6'h24: r.alu = 4'd0;
               6'h25: r.alu = 4'd1;
               6'h2a: r.alu = 4'd7;
               6'h00: if (shift_en) r.alu = 4'd4; else bad = 1'b1;
               6'h02: if (shift_en) r.alu = 4'd5; else bad = 1'b1;
               default: bad = 1'b1;
            endcase
         end
         6'h23: begin r.alusrc = 1'b1; r.memtoreg = 1'b1; r.regwrite = 1'b1; r.alu = 4'd2; end
         6'h2b: begin r.alusrc = 1'b1; r.memwrite = 1'b1; r.alu = 4'd2; end
         6'h04: begin r.branch = 1'b1; r.alu = 4'd6; end
         6'h05: if (bne_en) begin r.branch = 1'b1; r.bne = 1'b1; r.alu = 4'd6; end
                else bad = 1'b1;
         6'h08: begin r.alusrc = 1'b1; r.regwrite = 1'b1; r.alu = 4'd2; end
         6'h02: r.jump = 1'b1;
         default: bad = 1'b1;
      endcase
      if (bad) begin
         r.alu = 4'hF;
         r.illegal = 1'b1;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive, check stall mid-cycle, clock, check registers.
   task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic rn);
      ex_t nxt;
      bit  hz, st;
      logic [4:0] rs, rt;
      instr = ins; valid = v; flush = fl; rst_n = rn;
      rs = ins[25:21];
      rt = ins[20:16];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         hz = m_ex[k].valid && m_ex[k].memtoreg && (m_ex[k].rt != 5'd0) && v &&
              ((m_ex[k].rt == rs) || (reads_rt(ins[31:26]) && (m_ex[k].rt == rt)));
         st = !fl && (hz || (m_pend[k] > 0));
         if (m_known[k])
            check($sformatf("stall_%s", (k == 0) ? "a" : "b"),
                  64'((k == 0) ? a_stall : b_stall), 64'(st));
         if (!rn) begin
            m_ex[k] = '0; m_pend[k] = 0; m_cnt[k] = 0; m_known[k] = 1'b1;
         end else if (m_known[k]) begin
            if (st && (m_cnt[k] < cfg_max(k))) m_cnt[k]++;
            if (fl) m_pend[k] = 0;
            else if (hz) m_pend[k] = cfg_l(k) - 1;
            else if (m_pend[k] > 0) m_pend[k]--;
            if (fl || st || !v) begin
               nxt = '0;
               nxt.rs = ins[25:21]; nxt.rt = ins[20:16]; nxt.rd = ins[15:11];
            end else begin
               nxt = ref_decode(ins, k);
            end
            m_ex[k] = nxt;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (m_known[0]) begin
         check("idex_a", 64'(a_obs), 64'(m_ex[0]));
         check("cnt_a", 64'(a_cnt), 64'(m_cnt[0]));
      end
      if (m_known[1]) begin
         check("idex_b", 64'(b_obs), 64'(m_ex[1]));
         check("cnt_b", 64'(b_cnt), 64'(m_cnt[1]));
      end
      $display("[TB] cyc %0d in=%h v=%0d fl=%0d rn=%0d | a st=%0d ex=%h cnt=%0d | b st=%0d ex=%h cnt=%0d",
               cyc, ins, v, fl, rn, a_stall, a_obs, a_cnt, b_stall, b_obs, b_cnt);
   endtask

   function automatic logic [31:0] rtype(input int s, input int t, input int d, input logic [5:0] fn);
      return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int s, input int t, input int imm);
      return {op, 5'(s), 5'(t), 16'(imm)};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] fns [8];
      int s, t, d;
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h27};
      s = $urandom_range(0, 3);
      t = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      case ($urandom_range(0, 13))
         0, 1, 2, 3, 4, 5, 6: return rtype(s, t, d, fns[$urandom_range(0, 7)]);
         7:  return itype(6'h23, s, t, $urandom_range(0, 255));
         8:  return itype(6'h2b, s, t, $urandom_range(0, 255));
         9:  return itype(6'h04, s, t, $urandom_range(0, 255));
         10: return itype(6'h05, s, t, $urandom_range(0, 255));
         11: return itype(6'h08, s, t, $urandom_range(0, 255));
         12: return {6'h02, 26'($urandom)};
         default: return $urandom;
      endcase
   endfunction

   logic [31:0] add_in, lw_t0, add_dep, addi_ind, lw_zero, add_zero;
   logic [31:0] sweep [14];

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = '0; m_pend[k] = 0; m_cnt[k] = 0; m_known[k] = 1'b0;
      end
      add_in   = rtype(1, 2, 3, 6'h20);
      lw_t0    = itype(6'h23, 29, 8, 4);
      add_dep  = rtype(8, 10, 9, 6'h20);
      addi_ind = itype(6'h08, 11, 9, 4);
      lw_zero  = itype(6'h23, 1, 0, 8);
      add_zero = rtype(0, 0, 9, 6'h20);

      // Reset with a valid add sitting in ID
      step(add_in, 1'b1, 1'b0, 1'b0);
      step(add_in, 1'b1, 1'b0, 1'b0);
      check("rst_idex_a", 64'(a_obs), 64'd0);
      check("rst_cnt_b", 64'(b_cnt), 64'd0);

      // Load-use: fetch holds add until both configs have accepted it
      step(lw_t0, 1'b1, 1'b0, 1'b1);
      step(add_dep, 1'b1, 1'b0, 1'b1);
      step(add_dep, 1'b1, 1'b0, 1'b1);
      step(add_dep, 1'b1, 1'b0, 1'b1);
      check("lu_cnt_a", 64'(a_cnt), 64'd1);
      check("lu_cnt_b", 64'(b_cnt), 64'd2);

      // addi does not read rt: no stall
      step(lw_t0, 1'b1, 1'b0, 1'b1);
      step(addi_ind, 1'b1, 1'b0, 1'b1);
      // Hazard with simultaneous flush: flush wins
      step(lw_t0, 1'b1, 1'b0, 1'b1);
      step(add_dep, 1'b1, 1'b1, 1'b1);
      step(add_dep, 1'b1, 1'b0, 1'b1);
      // Load to $zero never creates a dependency
      step(lw_zero, 1'b1, 1'b0, 1'b1);
      step(add_zero, 1'b1, 1'b0, 1'b1);
      check("nostall_cnt_a", 64'(a_cnt), 64'd1);
      check("nostall_cnt_b", 64'(b_cnt), 64'd2);

      // Decode sweep
      sweep = '{rtype(1, 2, 3, 6'h20), rtype(1, 2, 3, 6'h22), rtype(1, 2, 3, 6'h24),
                rtype(1, 2, 3, 6'h25), rtype(1, 2, 3, 6'h2a), rtype(0, 2, 3, 6'h00),
                rtype(0, 2, 3, 6'h02), itype(6'h23, 4, 5, 16), itype(6'h2b, 6, 7, 20),
                itype(6'h04, 1, 2, 3), itype(6'h05, 1, 2, 3), itype(6'h08, 1, 2, 9),
                {6'h02, 26'h0123456}, rtype(1, 2, 3, 6'h27)};
      for (int i = 0; i < 14; i++)
         step(sweep[i], 1'b1, 1'b0, 1'b1);
      check("bad_funct_alu_a", 64'(a_alu), 64'hF);
      check("bad_funct_ill_b", 64'(b_illegal), 64'd1);

      // Reset in the middle of b's two-cycle stall
      step(lw_t0, 1'b1, 1'b0, 1'b1);
      step(add_dep, 1'b1, 1'b0, 1'b1);
      step(add_dep, 1'b1, 1'b0, 1'b0);
      step(add_dep, 1'b1, 1'b0, 1'b1);
      check("midrst_cnt_b", 64'(b_cnt), 64'd0);

      // Saturation of b's 4-bit counter
      for (int i = 0; i < 10; i++) begin
         step(lw_t0, 1'b1, 1'b0, 1'b1);
         step(add_dep, 1'b1, 1'b0, 1'b1);
         step(add_dep, 1'b1, 1'b0, 1'b1);
         step(add_dep, 1'b1, 1'b0, 1'b1);
      end
      check("sat_cnt_a", 64'(a_cnt), 64'd10);
      check("sat_cnt_b", 64'(b_cnt), 64'hF);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step(rand_instr(), ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
